// File: rtl/com_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : com_bus_arbiter
// Purpose  : Grants the shared common bus to the cache wrappers of the
//            4-core configuration. Two independent round-robin arbiters:
//              - proc arbiter : NUM_PROC requesters (4 D-caches + 4 I-caches)
//              - snoop arbiter: NUM_SNOOP D-cache snoop/writeback requesters
//            Each arbiter runs IDLE -> GRANT -> RELEASE. RELEASE is one
//            mandatory dead cycle for bus turnaround. The released winner
//            becomes lowest priority.
// Ports    : clk                single clock, rising edge
//            rst                asynchronous reset, active-high
//            Com_Bus_Req_proc   per-cache proc bus request (level)
//            Com_Bus_Gnt_proc   proc grant, one-hot or zero
//            Com_Bus_Req_snoop  per-D-cache snoop request (level)
//            Com_Bus_Gnt_snoop  snoop grant, one-hot or zero
//            Proc_owner         index of current proc grantee (valid if busy)
//            Bus_busy           high while any proc grant is asserted
//            Arb_timeout        1-cycle pulse on a forced proc release
// Config   : COM_BUS_ARB_TIMEOUT_EN - when defined, a proc grant held for
//            MAX_HOLD cycles is forcibly released. Undefined: grants are
//            held indefinitely and Arb_timeout stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module com_bus_arbiter #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int MAX_HOLD  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    output logic [2:0]           Proc_owner,
    output logic                 Bus_busy,
    output logic                 Arb_timeout
);

    localparam int PW  = (NUM_PROC  > 1) ? $clog2(NUM_PROC)  : 1;
    localparam int SW  = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
    localparam int PW1 = PW + 1;
    localparam int SW1 = SW + 1;

    // Pointer holds the last winner; resetting it to the top index makes
    // index 0 the first candidate of the upward scan.
    localparam logic [PW-1:0] PROC_PTR_RST  = PW'(NUM_PROC - 1);
    localparam logic [SW-1:0] SNOOP_PTR_RST = SW'(NUM_SNOOP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // First set request bit scanning upward from ptr+1, wrapping to 0.
    function automatic logic [PW-1:0] pick_proc(input logic [NUM_PROC-1:0] req,
                                                 input logic [PW-1:0]       ptr);
        logic [PW1-1:0] idx;
        logic           found;
        pick_proc = ptr;
        found     = 1'b0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            idx = {1'b0, ptr} + PW1'(i);
            if (idx >= PW1'(NUM_PROC)) idx = idx - PW1'(NUM_PROC);
            if (!found && req[idx[PW-1:0]]) begin
                found     = 1'b1;
                pick_proc = idx[PW-1:0];
            end
        end
    endfunction

    function automatic logic [SW-1:0] pick_snoop(input logic [NUM_SNOOP-1:0] req,
                                                  input logic [SW-1:0]        ptr);
        logic [SW1-1:0] idx;
        logic           found;
        pick_snoop = ptr;
        found      = 1'b0;
        for (int i = 1; i <= NUM_SNOOP; i++) begin
            idx = {1'b0, ptr} + SW1'(i);
            if (idx >= SW1'(NUM_SNOOP)) idx = idx - SW1'(NUM_SNOOP);
            if (!found && req[idx[SW-1:0]]) begin
                found      = 1'b1;
                pick_snoop = idx[SW-1:0];
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          proc_state_q, proc_state_d;
    logic [PW-1:0]       proc_ptr_q, proc_ptr_d;
    logic [PW-1:0]       proc_owner_q, proc_owner_d;
    logic [NUM_PROC-1:0] proc_gnt_q, proc_gnt_d;
    logic                proc_busy_q, proc_busy_d;
    logic                proc_timeout_q, proc_timeout_d;
    logic [PW-1:0]       proc_win;

    arb_state_t           snoop_state_q, snoop_state_d;
    logic [SW-1:0]        snoop_ptr_q, snoop_ptr_d;
    logic [SW-1:0]        snoop_owner_q, snoop_owner_d;
    logic [NUM_SNOOP-1:0] snoop_gnt_q, snoop_gnt_d;
    logic [SW-1:0]        snoop_win;

    logic                 hold_expired;

`ifdef COM_BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    // Counter reads MAX_HOLD-1 on the edge at which the grant has been
    // high for MAX_HOLD cycles.
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    assign hold_expired = (proc_state_q == GRANT) && (hold_q == HOLD_LAST);

    always_comb begin
        hold_d = '0;
        if (proc_state_q == GRANT) hold_d = hold_q + HW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign proc_win  = pick_proc(Com_Bus_Req_proc, proc_ptr_q);
    assign snoop_win = pick_snoop(Com_Bus_Req_snoop, snoop_ptr_q);

    // ------------------------------------------------------------------
    // Proc arbiter next-state
    // ------------------------------------------------------------------
    always_comb begin
        proc_state_d   = proc_state_q;
        proc_ptr_d     = proc_ptr_q;
        proc_owner_d   = proc_owner_q;
        proc_gnt_d     = proc_gnt_q;
        proc_timeout_d = 1'b0;
        case (proc_state_q)
            IDLE, RELEASE: begin
                proc_gnt_d   = '0;
                proc_state_d = IDLE;
                if (|Com_Bus_Req_proc) begin
                    proc_gnt_d[proc_win] = 1'b1;
                    proc_owner_d         = proc_win;
                    proc_state_d         = GRANT;
                end
            end
            GRANT: begin
                if (!Com_Bus_Req_proc[proc_owner_q] || hold_expired) begin
                    proc_gnt_d     = '0;
                    proc_ptr_d     = proc_owner_q;
                    proc_state_d   = RELEASE;
                    // A voluntary drop takes precedence: the pulse only
                    // marks releases forced while the request is still up.
                    proc_timeout_d = Com_Bus_Req_proc[proc_owner_q];
                end
            end
            default: begin
                proc_gnt_d   = '0;
                proc_state_d = IDLE;
            end
        endcase
        proc_busy_d = |proc_gnt_d;
    end

    // ------------------------------------------------------------------
    // Snoop arbiter next-state (never timed out)
    // ------------------------------------------------------------------
    always_comb begin
        snoop_state_d = snoop_state_q;
        snoop_ptr_d   = snoop_ptr_q;
        snoop_owner_d = snoop_owner_q;
        snoop_gnt_d   = snoop_gnt_q;
        case (snoop_state_q)
            IDLE, RELEASE: begin
                snoop_gnt_d   = '0;
                snoop_state_d = IDLE;
                if (|Com_Bus_Req_snoop) begin
                    snoop_gnt_d[snoop_win] = 1'b1;
                    snoop_owner_d          = snoop_win;
                    snoop_state_d          = GRANT;
                end
            end
            GRANT: begin
                if (!Com_Bus_Req_snoop[snoop_owner_q]) begin
                    snoop_gnt_d   = '0;
                    snoop_ptr_d   = snoop_owner_q;
                    snoop_state_d = RELEASE;
                end
            end
            default: begin
                snoop_gnt_d   = '0;
                snoop_state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_state_q   <= IDLE;
            proc_ptr_q     <= PROC_PTR_RST;
            proc_owner_q   <= '0;
            proc_gnt_q     <= '0;
            proc_busy_q    <= 1'b0;
            proc_timeout_q <= 1'b0;
            snoop_state_q  <= IDLE;
            snoop_ptr_q    <= SNOOP_PTR_RST;
            snoop_owner_q  <= '0;
            snoop_gnt_q    <= '0;
        end else begin
            proc_state_q   <= proc_state_d;
            proc_ptr_q     <= proc_ptr_d;
            proc_owner_q   <= proc_owner_d;
            proc_gnt_q     <= proc_gnt_d;
            proc_busy_q    <= proc_busy_d;
            proc_timeout_q <= proc_timeout_d;
            snoop_state_q  <= snoop_state_d;
            snoop_ptr_q    <= snoop_ptr_d;
            snoop_owner_q  <= snoop_owner_d;
            snoop_gnt_q    <= snoop_gnt_d;
        end
    end

    assign Com_Bus_Gnt_proc  = proc_gnt_q;
    assign Com_Bus_Gnt_snoop = snoop_gnt_q;
    assign Proc_owner        = 3'(proc_owner_q);
    assign Bus_busy          = proc_busy_q;
    assign Arb_timeout       = proc_timeout_q;

endmodule
`default_nettype wire
